// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller slice.
// MEM_TIMEOUT_EN (when defined) enables the wait-cycle timeout in mem_ctrl.
package mem_ctrl_pkg;

  localparam int BUS_W           = 16;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_wait_cnt.sv
// Consecutive wait-cycle counter; flags the edge on which the limit is reached.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_wait_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expire on the wait edge that would bring the count up to LIMIT.
  assign o_expire = i_inc && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding memory access controller between the sequencer/MDR and memory.
// Optional timeout abort is compiled in with MEM_TIMEOUT_EN.
//
// Handshake: RD_REQ/WR_REQ are sampled only in IDLE (read wins); there is no ready
// back-pressure or queuing, and DONE is the single one-cycle completion beat,
// with MMD/M_bus valid in that same cycle for a successful read.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             RD_REQ,
  input  logic             WR_REQ,
  input  logic [BUS_W-1:0] MAR_q,
  input  logic [BUS_W-1:0] MDR_to_M,
  output logic [BUS_W-1:0] M_bus,
  output logic             MMD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [BUS_W-1:0] MEM_ADDR,
  output logic [BUS_W-1:0] MEM_WDATA,
  output logic             MEM_RE,
  output logic             MEM_WE,
  input  logic [BUS_W-1:0] MEM_RDATA,
  input  logic             MEM_RDY,
  output state_t           DBG_STATE
);

  state_t           r_state;
  state_t           w_next;
  logic [BUS_W-1:0] r_addr;
  logic [BUS_W-1:0] r_wdata;
  logic [BUS_W-1:0] r_rdata;
  logic             r_is_rd;
  logic             w_accept;
  logic             w_expire;
  logic             w_err;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_is_rd <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && RD_REQ) begin
        r_addr  <= MAR_q;
        r_wdata <= '0;
        r_is_rd <= 1'b1;
      end else if (r_state == IDLE && WR_REQ) begin
        r_addr  <= MAR_q;
        r_wdata <= MDR_to_M;
        r_is_rd <= 1'b0;
      end
      if (r_state == READ && MEM_RDY) begin
        r_rdata <= MEM_RDATA;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic r_err;
  logic w_wait;

  assign w_wait = ((r_state == READ) || (r_state == WRITE)) && !MEM_RDY;

  mem_wait_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .i_clk   (CLK),
    .i_rst_n (CLR),
    .i_clear (w_accept),
    .i_inc   (w_wait),
    .o_expire(w_expire)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign w_err = r_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = |TIMEOUT_CYCLES;
  assign w_expire     = 1'b0;
  assign w_err        = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;
    MMD       = 1'b0;
    M_bus     = '0;
    MEM_RE    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    case (r_state)
      IDLE: begin
        if (RD_REQ) begin
          w_next   = READ;
          w_accept = 1'b1;
        end else if (WR_REQ) begin
          w_next   = WRITE;
          w_accept = 1'b1;
        end
      end
      READ: begin
        BUSY     = 1'b1;
        MEM_RE   = 1'b1;
        MEM_ADDR = r_addr;
        if (MEM_RDY || w_expire) w_next = FIN;
      end
      WRITE: begin
        BUSY      = 1'b1;
        MEM_WE    = 1'b1;
        MEM_ADDR  = r_addr;
        MEM_WDATA = r_wdata;
        if (MEM_RDY || w_expire) w_next = FIN;
      end
      FIN: begin
        DONE   = 1'b1;
        ERR    = w_err;
        // An aborted read must not load stale data into the MDR.
        MMD    = r_is_rd && !w_err;
        M_bus  = (r_is_rd && !w_err) ? r_rdata : '0;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl; builds with or without MEM_TIMEOUT_EN.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        RD_REQ = 1'b0;
  logic        WR_REQ = 1'b0;
  logic [15:0] MAR_q = '0;
  logic [15:0] MDR_to_M = '0;
  logic [15:0] M_bus;
  logic        MMD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        MEM_RE;
  logic        MEM_WE;
  logic [15:0] MEM_RDATA = '0;
  logic        MEM_RDY = 1'b0;
  state_t      DBG_STATE;

  logic [5:0]  flags;
  int          total = 0;
  int          bad = 0;

  assign flags = {BUSY, DONE, ERR, MMD, MEM_RE, MEM_WE};

  mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .CLR(CLR), .RD_REQ(RD_REQ), .WR_REQ(WR_REQ),
    .MAR_q(MAR_q), .MDR_to_M(MDR_to_M), .M_bus(M_bus), .MMD(MMD),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_RDATA(MEM_RDATA), .MEM_RDY(MEM_RDY), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    CLR = 1'b0;
    #3;
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL reset_flags: got %b want %b", flags, 6'b000000); end
    total++;
    if (MEM_ADDR !== 16'h0000 || MEM_WDATA !== 16'h0000 || M_bus !== 16'h0000) begin
      bad++; $display("FAIL reset_buses: got addr=%h wdata=%h mbus=%h want 0", MEM_ADDR, MEM_WDATA, M_bus);
    end
    total++;
    if (DBG_STATE !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", DBG_STATE, IDLE); end
    tick;
    tick;
    CLR = 1'b1;
  endtask

  task automatic test_read;
    RD_REQ = 1'b1; MAR_q = 16'h0012; MEM_RDY = 1'b1; MEM_RDATA = 16'h00A5;
    tick;
    RD_REQ = 1'b0; MAR_q = 16'hFFFF;
    total++;
    if (flags !== 6'b100010) begin bad++; $display("FAIL read_access_flags: got %b want %b", flags, 6'b100010); end
    total++;
    if (MEM_ADDR !== 16'h0012) begin bad++; $display("FAIL read_addr: got %h want %h", MEM_ADDR, 16'h0012); end
    tick;
    total++;
    if (flags !== 6'b010100) begin bad++; $display("FAIL read_fin_flags: got %b want %b", flags, 6'b010100); end
    total++;
    if (M_bus !== 16'h00A5 || MEM_ADDR !== 16'h0000) begin
      bad++; $display("FAIL read_fin_bus: got mbus=%h addr=%h want mbus=00a5 addr=0000", M_bus, MEM_ADDR);
    end
    tick;
    total++;
    if (flags !== 6'b000000 || M_bus !== 16'h0000) begin
      bad++; $display("FAIL read_after: got flags=%b mbus=%h want 000000/0000", flags, M_bus);
    end
  endtask

  task automatic test_write_wait;
    WR_REQ = 1'b1; MAR_q = 16'h0034; MDR_to_M = 16'h005A; MEM_RDY = 1'b0;
    tick;
    WR_REQ = 1'b0; MAR_q = 16'h0000; MDR_to_M = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (flags !== 6'b100001 || MEM_WDATA !== 16'h005A || MEM_ADDR !== 16'h0034) begin
        bad++; $display("FAIL write_cycle%0d: got flags=%b wdata=%h addr=%h want 100001/005a/0034",
                        i, flags, MEM_WDATA, MEM_ADDR);
      end
      if (i == 3) MEM_RDY = 1'b1;
      tick;
    end
    total++;
    if (flags !== 6'b010000 || M_bus !== 16'h0000 || MEM_WDATA !== 16'h0000) begin
      bad++; $display("FAIL write_fin: got flags=%b mbus=%h wdata=%h want 010000/0000/0000", flags, M_bus, MEM_WDATA);
    end
    tick;
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL write_after: got %b want %b", flags, 6'b000000); end
  endtask

  task automatic test_both_req;
    RD_REQ = 1'b1; WR_REQ = 1'b1; MAR_q = 16'h0077; MDR_to_M = 16'hBEEF;
    MEM_RDY = 1'b1; MEM_RDATA = 16'h1111;
    tick;
    RD_REQ = 1'b0; WR_REQ = 1'b0;
    total++;
    if (flags !== 6'b100010 || MEM_WDATA !== 16'h0000) begin
      bad++; $display("FAIL both_access: got flags=%b wdata=%h want 100010/0000", flags, MEM_WDATA);
    end
    tick;
    total++;
    if (flags !== 6'b010100 || M_bus !== 16'h1111) begin
      bad++; $display("FAIL both_fin: got flags=%b mbus=%h want 010100/1111", flags, M_bus);
    end
    tick;
    tick;
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL both_write_dropped: got %b want %b", flags, 6'b000000); end
  endtask

  task automatic test_reset_mid;
    RD_REQ = 1'b1; MAR_q = 16'h00C3; MEM_RDY = 1'b0;
    tick;
    RD_REQ = 1'b0;
    tick;
    total++;
    if (flags !== 6'b100010) begin bad++; $display("FAIL rst_mid_wait: got %b want %b", flags, 6'b100010); end
    #2 CLR = 1'b0;
    #1;
    total++;
    if (flags !== 6'b000000 || MEM_ADDR !== 16'h0000 || DBG_STATE !== IDLE) begin
      bad++; $display("FAIL rst_mid_async: got flags=%b addr=%h state=%0d want 000000/0000/0", flags, MEM_ADDR, DBG_STATE);
    end
    MEM_RDY = 1'b1;
    tick;
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL rst_mid_no_done: got %b want %b", flags, 6'b000000); end
    @(negedge CLK);
    CLR = 1'b1; RD_REQ = 1'b1; MAR_q = 16'h00C3; MEM_RDATA = 16'h3C3C;
    tick;
    RD_REQ = 1'b0;
    total++;
    if (flags !== 6'b100010 || MEM_ADDR !== 16'h00C3) begin
      bad++; $display("FAIL rst_mid_reaccept: got flags=%b addr=%h want 100010/00c3", flags, MEM_ADDR);
    end
    tick;
    total++;
    if (flags !== 6'b010100 || M_bus !== 16'h3C3C) begin
      bad++; $display("FAIL rst_mid_fin: got flags=%b mbus=%h want 010100/3c3c", flags, M_bus);
    end
    tick;
  endtask

  task automatic test_timeout;
    RD_REQ = 1'b1; MAR_q = 16'h0099; MEM_RDY = 1'b0; MEM_RDATA = 16'hFFFF;
    tick;
    RD_REQ = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if (flags !== 6'b100010) begin bad++; $display("FAIL timeout_wait%0d: got %b want %b", i, flags, 6'b100010); end
      tick;
    end
    total++;
    if (flags !== 6'b011000 || M_bus !== 16'h0000) begin
      bad++; $display("FAIL timeout_abort: got flags=%b mbus=%h want 011000/0000", flags, M_bus);
    end
    tick;
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL timeout_after: got %b want %b", flags, 6'b000000); end
`else
    for (int i = 0; i < 40; i++) begin
      total++;
      if (flags !== 6'b100010) begin bad++; $display("FAIL no_timeout_wait%0d: got %b want %b", i, flags, 6'b100010); end
      tick;
    end
    MEM_RDY = 1'b1; MEM_RDATA = 16'h5555;
    tick;
    total++;
    if (flags !== 6'b010100 || M_bus !== 16'h5555) begin
      bad++; $display("FAIL no_timeout_fin: got flags=%b mbus=%h want 010100/5555", flags, M_bus);
    end
    tick;
`endif
  endtask

  task automatic test_fin_hold;
    RD_REQ = 1'b1; MAR_q = 16'h0055; MEM_RDY = 1'b1; MEM_RDATA = 16'h0ABC;
    tick;
    MAR_q = 16'h0056;
    total++;
    if (flags !== 6'b100010 || MEM_ADDR !== 16'h0055) begin
      bad++; $display("FAIL hold_latched_addr: got flags=%b addr=%h want 100010/0055", flags, MEM_ADDR);
    end
    tick;
    total++;
    if (flags !== 6'b010100 || M_bus !== 16'h0ABC) begin
      bad++; $display("FAIL hold_fin: got flags=%b mbus=%h want 010100/0abc", flags, M_bus);
    end
    tick;
    total++;
    if (flags !== 6'b000000) begin bad++; $display("FAIL hold_ignored_in_fin: got %b want %b", flags, 6'b000000); end
    tick;
    RD_REQ = 1'b0;
    total++;
    if (flags !== 6'b100010 || MEM_ADDR !== 16'h0056) begin
      bad++; $display("FAIL hold_reaccept: got flags=%b addr=%h want 100010/0056", flags, MEM_ADDR);
    end
    tick;
    total++;
    if (flags !== 6'b010100) begin bad++; $display("FAIL hold_second_fin: got %b want %b", flags, 6'b010100); end
    tick;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_wait;
    test_both_req;
    test_reset_mid;
    test_timeout;
    test_fin_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
